// File: rtl/fft_sink_pkg.sv
// Shared types and constants for the fft_axis_sink capture block.
package fft_sink_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CAPTURE = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
  localparam int              LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Beat counter must hold BUF_DEPTH itself, hence one extra bit
  function automatic int cnt_width(input int depth_log);
    return depth_log + 32'sd1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(32'sd10);

endpackage

// File: rtl/fft_sink_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module fft_sink_ram #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [DWIDTH-1:0] rdata_r;

  // Write port; storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port; NBA ordering yields the old word on a same-address collision
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= {DWIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/fft_axis_sink.sv
// AXI4-Stream frame capture with tlast framing checks and random-access readback.
// Optional macro BACKPRESSURE_EN gates tready with an LFSR to exercise upstream stalls.
module fft_axis_sink
  import fft_sink_pkg::*;
#(
  parameter int          DWIDTH        = 32,
  parameter int          BUF_DEPTH     = 1024,
  parameter int          BUF_DEPTH_LOG = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              i_point,
  input  logic                     i_start,
  input  logic [DWIDTH-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic                     i_rd_en,
  input  logic [BUF_DEPTH_LOG-1:0] i_rd_addr,
  output logic [DWIDTH-1:0]        o_rd_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [BUF_DEPTH_LOG:0]   o_frame_len,
  output logic                     o_err_early_last,
  output logic                     o_err_missing_last,
  output logic                     o_err_cfg
);

  localparam int CW = cnt_width(BUF_DEPTH_LOG);

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, len_r, frame_len_r;
  logic          tready_r, busy_r, done_r, early_r, missing_r, cfg_err_r;
  logic          legal_s, arm_s, cfg_bad_s, beat_s, at_end_s, close_s;
  logic          ready_gate_s;

  // Arm/close decode and next-state selection
  always_comb begin
    legal_s     = (i_point != 11'd0) && ({21'd0, i_point} <= 32'(BUF_DEPTH));
    beat_s      = s_axis_tvalid & tready_r;
    at_end_s    = (cnt_r == (len_r - CW'(1'b1)));
    arm_s       = 1'b0;
    cfg_bad_s   = 1'b0;
    close_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (i_start && legal_s) begin
          arm_s       = 1'b1;
          state_nxt_s = ST_CAPTURE;
        end else if (i_start) begin
          cfg_bad_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CAPTURE: begin
        if (beat_s && (s_axis_tlast || at_end_s)) begin
          close_s     = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

`ifdef BACKPRESSURE_EN
  logic [LFSR_W-1:0] lfsr_r, lfsr_nxt_s;

  // LFSR restarts from the seed on every arm so stall patterns are repeatable
  always_comb begin
    if (arm_s) begin
      lfsr_nxt_s = LFSR_SEED;
    end else if (state_r == ST_CAPTURE) begin
      lfsr_nxt_s = {lfsr_r[LFSR_W-2:0], ^(lfsr_r & LFSR_TAPS)};
    end else begin
      lfsr_nxt_s = lfsr_r;
    end
  end

  // LFSR state
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_nxt_s;
    end
  end

  assign ready_gate_s = lfsr_nxt_s[0] | lfsr_nxt_s[1];
`else
  logic seed_unused_s;
  assign seed_unused_s = ^LFSR_SEED;
  assign ready_gate_s  = 1'b1;
`endif

  // Frame control, counters and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      tready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      len_r       <= {CW{1'b0}};
      frame_len_r <= {CW{1'b0}};
      early_r     <= 1'b0;
      missing_r   <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      busy_r   <= (state_nxt_s == ST_CAPTURE);
      done_r   <= (state_nxt_s == ST_DONE);
      tready_r <= (state_nxt_s == ST_CAPTURE) & ready_gate_s;
      if (arm_s) begin
        len_r       <= CW'(i_point);
        cnt_r       <= {CW{1'b0}};
        frame_len_r <= {CW{1'b0}};
        early_r     <= 1'b0;
        missing_r   <= 1'b0;
        cfg_err_r   <= 1'b0;
      end else if (cfg_bad_s) begin
        cfg_err_r <= 1'b1;
      end else if (beat_s && (state_r == ST_CAPTURE)) begin
        cnt_r <= cnt_r + CW'(1'b1);
        if (close_s) begin
          frame_len_r <= cnt_r + CW'(1'b1);
          early_r     <= s_axis_tlast & ~at_end_s;
          missing_r   <= at_end_s & ~s_axis_tlast;
        end
      end
    end
  end

  fft_sink_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (BUF_DEPTH),
    .AW     (BUF_DEPTH_LOG)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (beat_s),
    .waddr (cnt_r[BUF_DEPTH_LOG-1:0]),
    .wdata (s_axis_tdata),
    .re    (i_rd_en),
    .raddr (i_rd_addr),
    .rdata (o_rd_data)
  );

  assign s_axis_tready      = tready_r;
  assign o_busy             = busy_r;
  assign o_done             = done_r;
  assign o_frame_len        = frame_len_r;
  assign o_err_early_last   = early_r;
  assign o_err_missing_last = missing_r;
  assign o_err_cfg          = cfg_err_r;

endmodule

// File: tb/tb_fft_axis_sink.sv
// Scoreboarded bench for fft_axis_sink: random frames against a frame-level model.
module tb_fft_axis_sink;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   i_point;
  logic          i_start;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_frame_len;
  logic          o_err_early_last;
  logic          o_err_missing_last;
  logic          o_err_cfg;

  fft_axis_sink dut (
    .clk                (clk),
    .reset              (reset),
    .i_point            (i_point),
    .i_start            (i_start),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .i_rd_en            (i_rd_en),
    .i_rd_addr          (i_rd_addr),
    .o_rd_data          (o_rd_data),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_frame_len        (o_frame_len),
    .o_err_early_last   (o_err_early_last),
    .o_err_missing_last (o_err_missing_last),
    .o_err_cfg          (o_err_cfg)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            stall_cnt = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] rd_q [$];
  logic [DW-1:0] rd_exp;
  logic          rd_pend = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-port monitor: one result due the cycle after each i_rd_en
  always @(posedge clk) rd_pend <= i_rd_en & ~reset;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", o_rd_data);
      end else begin
        rd_exp = rd_q.pop_front();
        chk("rd_data", o_rd_data, rd_exp);
      end
    end
    if (s_axis_tvalid && !s_axis_tready && o_busy) stall_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int p);
    i_point = 11'(p);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Offers n_offer beats; the model decides which must be taken and which stall
  task automatic frame(input int len, input int tlast_at, input int n_offer,
                       input bit gappy, input bit collide, input bit seq,
                       output int acc, output bit early, output bit miss);
    logic [DW-1:0] d;
    bit took;
    int w, limit;
    acc   = (tlast_at >= 0 && tlast_at < len) ? tlast_at + 1 : len;
    early = (tlast_at >= 0 && tlast_at < len - 1);
    miss  = !early && (tlast_at != len - 1);
    for (int k = 0; k < n_offer; k++) begin
      d = seq ? DW'(k) : $urandom;
      if (gappy) begin
        s_axis_tvalid = 1'b0;
        tick();
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = (k == tlast_at);
      limit = (k < acc) ? 200 : 6;
      took  = 1'b0;
      w     = 0;
      while (!took && w < limit) begin
        @(negedge clk);
        if (s_axis_tready) begin
          took = 1'b1;
          if (collide && k < acc) begin
            i_rd_en   = 1'b1;
            i_rd_addr = AW'(k);
            rd_q.push_back(model_mem[k]);
          end
        end
        tick();
        i_rd_en = 1'b0;
        w++;
      end
      if (k < acc) begin
        chk("beat_accept", took, 1);
        if (took) model_mem[k] = d;
      end else begin
        chk("excess_stalled", took, 0);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_status(input bit done, input bit busy, input int flen,
                              input bit early, input bit miss, input bit cfg);
    @(negedge clk);
    chk("o_done", o_done, done);
    chk("o_busy", o_busy, busy);
    chk("o_frame_len", o_frame_len, flen);
    chk("o_err_early_last", o_err_early_last, early);
    chk("o_err_missing_last", o_err_missing_last, miss);
    chk("o_err_cfg", o_err_cfg, cfg);
    if (!busy) chk("tready_idle", s_axis_tready, 0);
    tick();
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      i_rd_en   = 1'b1;
      i_rd_addr = AW'(a);
      rd_q.push_back(model_mem[a]);
      tick();
    end
    i_rd_en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, len, tl, r;
    bit e, m;
    reset = 1'b1; i_point = 11'd0; i_start = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    i_rd_en = 1'b0; i_rd_addr = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_frame_len", o_frame_len, 0);
    chk("rst_errs", {o_err_early_last, o_err_missing_last, o_err_cfg}, 0);
    chk("rst_rd_data", o_rd_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // Clean 16-point frame with counting data
    arm(16);
    @(negedge clk);
    chk("arm_busy", o_busy, 1);
`ifndef BACKPRESSURE_EN
    chk("arm_tready", s_axis_tready, 1);
`endif
    tick();
    frame(16, 15, 16, 1'b0, 1'b0, 1'b1, acc, e, m);
    check_status(1'b1, 1'b0, acc, e, m, 1'b0);
    read_range(0, 15);
    @(negedge clk);
    chk("rd_hold", o_rd_data, model_mem[15]);
    tick();

    // Reads colliding with writes must see the previous frame's data
    arm(16);
    frame(16, 15, 16, 1'b0, 1'b1, 1'b0, acc, e, m);
    check_status(1'b1, 1'b0, acc, e, m, 1'b0);
    read_range(0, 15);

    // Early tlast on beat 8
    arm(16);
    frame(16, 7, 16, 1'b0, 1'b0, 1'b0, acc, e, m);
    check_status(1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b0);
    read_range(0, 7);

    // Missing tlast; 17th beat must stall
    arm(16);
    frame(16, -1, 17, 1'b0, 1'b0, 1'b0, acc, e, m);
    check_status(1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0);

    // i_start ignored in CAPTURE, then reset mid-frame
    arm(16);
    frame(16, -1, 5, 1'b0, 1'b0, 1'b0, acc, e, m);
    i_point = 11'd0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    @(negedge clk);
    chk("start_in_capture_cfg", o_err_cfg, 0);
    chk("start_in_capture_busy", o_busy, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_tready", s_axis_tready, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_frame_len", o_frame_len, 0);
    tick();
    arm(16);
    frame(16, 15, 16, 1'b0, 1'b0, 1'b0, acc, e, m);
    check_status(1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0);
    read_range(0, 15);

    // Illegal configs: from DONE drops to IDLE, frame_len retained
    arm(0);
    check_status(1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1);
    arm(1025);
    check_status(1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1);

    // Full-depth frame with tvalid gaps
    arm(1024);
    @(negedge clk);
    chk("rearm_cfg_clear", o_err_cfg, 0);
    tick();
    frame(1024, 1023, 1024, 1'b1, 1'b0, 1'b0, acc, e, m);
    check_status(1'b1, 1'b0, 1024, 1'b0, 1'b0, 1'b0);
    read_range(0, 3);
    read_range(1020, 1023);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 48);
      r   = $urandom_range(0, 2);
      tl  = (r == 0) ? len - 1 : (r == 1) ? -1 : $urandom_range(0, len - 1);
      arm(len);
      frame(len, tl, len + 2, 1'(r == 2), 1'b0, 1'b0, acc, e, m);
      check_status(1'b1, 1'b0, acc, e, m, 1'b0);
      read_range(0, acc - 1);
    end

    // 64-point frame with tvalid held high
    stall_cnt = 0;
    arm(64);
    frame(64, 63, 64, 1'b0, 1'b0, 1'b0, acc, e, m);
    check_status(1'b1, 1'b0, 64, 1'b0, 1'b0, 1'b0);
    read_range(0, 63);
`ifdef BACKPRESSURE_EN
    chk("backpressure_seen", stall_cnt > 0, 1);
`else
    chk("no_backpressure", stall_cnt, 0);
`endif

    repeat (3) tick();
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
